// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-memory port bundle for the load/store controller.
// slave is the controller's view; master is the execute stage plus memory side.
interface lsu_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: byte/half/word loads with extension, sub-word stores
// as read-modify-write on a big-endian word memory, alignment/range faults.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_BYTES = 512,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic clk,
    input  logic rst_n,
    lsu_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ST_WORD,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t state, state_next;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_fault_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              accept;
    logic              req_fault;
    logic [2:0]        nbytes;
    logic [ADDR_W:0]   req_end;
    logic [31:0]       load_ext;
    logic [31:0]       merged;
    logic              ready;
    logic              resp_valid;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    // Range check is done one bit wider so addresses near the top cannot wrap.
    always_comb begin
        case (bus.req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        req_end   = {1'b0, bus.req_addr} + (ADDR_W+1)'(nbytes);
        req_fault = (bus.req_size == 2'b11)
                 || (bus.req_size == 2'b01 && bus.req_addr[0])
                 || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                 || (req_end > (ADDR_W+1)'(MEM_BYTES));
    end

    always_comb begin
        load_ext = '0;
        case (size_q)
            2'b00: begin
                logic [7:0] b;
                case (off_q)
                    2'd0:    b = bus.mem_rdata[31:24];
                    2'd1:    b = bus.mem_rdata[23:16];
                    2'd2:    b = bus.mem_rdata[15:8];
                    default: b = bus.mem_rdata[7:0];
                endcase
                load_ext = {{24{b[7] & ~uns_q}}, b};
            end
            2'b01: begin
                logic [15:0] h;
                h = off_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
                load_ext = {{16{h[15] & ~uns_q}}, h};
            end
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        merged = merge_q;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[15:0] = wdata_q[15:0];
        end else begin
            merged[31:16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // mem_we and resp_valid are decoded from state so an async reset kills them at once.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ready      = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (req_fault)                  state_next = RESP;
                    else if (!bus.req_we)           state_next = LOAD;
                    else if (bus.req_size == 2'b10) state_next = ST_WORD;
                    else                            state_next = RMW_RD;
                end
            end
            LOAD:    state_next = RESP;
            ST_WORD: begin
                mem_we     = 1'b1;
                mem_wdata  = wdata_q;
                state_next = RESP;
            end
            RMW_RD:  state_next = RMW_WR;
            RMW_WR: begin
                mem_we     = 1'b1;
                mem_wdata  = merged;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            off_q        <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            if (accept) begin
                we_q         <= bus.req_we;
                size_q       <= bus.req_size;
                uns_q        <= bus.req_unsigned;
                off_q        <= bus.req_addr[1:0];
                wdata_q      <= bus.req_wdata;
                resp_rdata_q <= '0;
                resp_fault_q <= req_fault;
                if (!req_fault) mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            end
            if (state == LOAD)   resp_rdata_q <= load_ext;
            if (state == RMW_RD) merge_q      <= bus.mem_rdata;
            if (state == RESP) begin
                resp_rdata_q <= '0;
                resp_fault_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we;
    assign bus.mem_wdata  = mem_wdata;

endmodule
